// File: rtl/axi_dma_cmd_arb_pkg.sv
// rtl/axi_dma_cmd_arb_pkg.sv - shared AXI DMA burst/size encodings, arbiter states and size limit helper
package axi_dma_defs;

    // AXI burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // AXI size encodings (bytes per beat = 2**size)
    localparam logic [2:0] SIZE_1B   = 3'd0;
    localparam logic [2:0] SIZE_2B   = 3'd1;
    localparam logic [2:0] SIZE_4B   = 3'd2;
    localparam logic [2:0] SIZE_8B   = 3'd3;
    localparam logic [2:0] SIZE_16B  = 3'd4;
    localparam logic [2:0] SIZE_32B  = 3'd5;
    localparam logic [2:0] SIZE_64B  = 3'd6;
    localparam logic [2:0] SIZE_128B = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    // Largest legal beat size for a bus of data_wd bits: log2(data_wd/8)
    function automatic int MAX_SIZE(input int data_wd);
        int s;
        s = 0;
        for (int b = data_wd / 8; b > 1; b = b / 2) begin
            s = s + 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_dma_cmd_arb_rr_arb_core.sv
// rtl/axi_dma_cmd_arb_rr_arb_core.sv - combinational round-robin picker starting from rr_ptr
module rr_arb_core #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // Walk upward from rr_ptr with wrap; first set mask bit wins
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_grant && req_mask[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/axi_dma_cmd_arb.sv
// rtl/axi_dma_cmd_arb.sv - round-robin arbiter sharing one DMA command port between requesters
module axi_dma_cmd_arb
    import axi_dma_defs::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_ADDR_WD = 16,
    parameter int AXI_DATA_WD = 32
) (
    input  logic                           AXI_ACLK,
    input  logic                           AXI_ARESETN,
    input  logic [NUM_REQ-1:0]             cfg_en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*AXI_ADDR_WD-1:0] req_addr,
    input  logic [NUM_REQ*AXI_ADDR_WD-1:0] req_len,
    input  logic [NUM_REQ*3-1:0]           req_size,
    input  logic [NUM_REQ*2-1:0]           req_burst,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_err,
    output logic [NUM_REQ-1:0]             req_abort,
    output logic                           cmd_valid,
    output logic [AXI_ADDR_WD-1:0]         cmd_addr,
    output logic [AXI_ID_WD-1:0]           cmd_id,
    output logic [1:0]                     cmd_burst,
    output logic [2:0]                     cmd_size,
    output logic [AXI_ADDR_WD-1:0]         cmd_len,
    input  logic                           cmd_ready,
    input  logic                           cmd_abort
);

    localparam int         IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] MAX_SZ = 3'(MAX_SIZE(AXI_DATA_WD));

    // Per-requester views of the flattened request buses
    logic [AXI_ADDR_WD-1:0] addr_arr  [NUM_REQ];
    logic [AXI_ADDR_WD-1:0] len_arr   [NUM_REQ];
    logic [2:0]             size_arr  [NUM_REQ];
    logic [1:0]             burst_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*AXI_ADDR_WD +: AXI_ADDR_WD];
        assign len_arr[i]   = req_len[i*AXI_ADDR_WD +: AXI_ADDR_WD];
        assign size_arr[i]  = req_size[i*3 +: 3];
        assign burst_arr[i] = req_burst[i*2 +: 2];
    end

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   last_vld_q, last_vld_d;
    logic [AXI_ID_WD-1:0]   last_id_q, last_id_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [AXI_ADDR_WD-1:0] cmd_addr_q, cmd_addr_d;
    logic [AXI_ADDR_WD-1:0] cmd_len_q, cmd_len_d;
    logic [2:0]             cmd_size_q, cmd_size_d;
    logic [1:0]             cmd_burst_q, cmd_burst_d;
    logic [AXI_ID_WD-1:0]   cmd_id_q, cmd_id_d;
    logic [NUM_REQ-1:0]     req_err_q, req_err_d;
    logic [NUM_REQ-1:0]     req_abort_q, req_abort_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any_grant;
    logic                   win_legal;
    logic [IDX_W-1:0]       next_ptr;

    rr_arb_core #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb_core (
        .req_mask  (req_valid & cfg_en),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign win_legal = (len_arr[grant_idx] != '0)
                    && (burst_arr[grant_idx] != BURST_RSVD)
                    && (size_arr[grant_idx] <= MAX_SZ);

    assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Next-state, grant/validation, command capture and abort routing
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        last_vld_d  = last_vld_q;
        last_id_d   = last_id_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_size_d  = cmd_size_q;
        cmd_burst_d = cmd_burst_q;
        cmd_id_d    = cmd_id_q;
        req_err_d   = '0;
        req_abort_d = '0;
        req_ready   = '0;

        // Uses the pre-handshake last_id so an abort on a handshake edge hits the older command
        if (cmd_abort && last_vld_q) begin
            req_abort_d = NUM_REQ'(1) << last_id_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (any_grant) begin
                    req_ready = grant;
                    rr_ptr_d  = next_ptr;
                    if (win_legal) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = addr_arr[grant_idx];
                        cmd_len_d   = len_arr[grant_idx];
                        cmd_size_d  = size_arr[grant_idx];
                        cmd_burst_d = burst_arr[grant_idx];
                        cmd_id_d    = AXI_ID_WD'(grant_idx);
                        state_d     = ST_ISSUE;
                    end else begin
                        req_err_d = grant;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    last_id_d   = cmd_id_q;
                    last_vld_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and registered outputs; reset drops any held command
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            last_vld_q  <= 1'b0;
            last_id_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_size_q  <= '0;
            cmd_burst_q <= '0;
            cmd_id_q    <= '0;
            req_err_q   <= '0;
            req_abort_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            last_vld_q  <= last_vld_d;
            last_id_q   <= last_id_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_size_q  <= cmd_size_d;
            cmd_burst_q <= cmd_burst_d;
            cmd_id_q    <= cmd_id_d;
            req_err_q   <= req_err_d;
            req_abort_q <= req_abort_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_size  = cmd_size_q;
    assign cmd_burst = cmd_burst_q;
    assign cmd_id    = cmd_id_q;
    assign req_err   = req_err_q;
    assign req_abort = req_abort_q;

endmodule

// File: tb/tb_axi_dma_cmd_arb.sv
// tb/tb_axi_dma_cmd_arb.sv - scoreboard bench for axi_dma_cmd_arb
module tb_axi_dma_cmd_arb;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int IW = 2;
    localparam int DW = 32;
    localparam logic [2:0] TB_MAX_SIZE = 3'd2;

    logic              AXI_ACLK = 1'b0;
    logic              AXI_ARESETN = 1'b0;
    logic [N-1:0]      cfg_en;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*AW-1:0]   req_len;
    logic [N*3-1:0]    req_size;
    logic [N*2-1:0]    req_burst;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_err;
    logic [N-1:0]      req_abort;
    logic              cmd_valid;
    logic [AW-1:0]     cmd_addr;
    logic [IW-1:0]     cmd_id;
    logic [1:0]        cmd_burst;
    logic [2:0]        cmd_size;
    logic [AW-1:0]     cmd_len;
    logic              cmd_ready;
    logic              cmd_abort;

    always #5 AXI_ACLK = ~AXI_ACLK;

    axi_dma_cmd_arb #(
        .NUM_REQ     (N),
        .AXI_ID_WD   (IW),
        .AXI_ADDR_WD (AW),
        .AXI_DATA_WD (DW)
    ) dut (
        .AXI_ACLK    (AXI_ACLK),
        .AXI_ARESETN (AXI_ARESETN),
        .cfg_en      (cfg_en),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_size    (req_size),
        .req_burst   (req_burst),
        .req_ready   (req_ready),
        .req_err     (req_err),
        .req_abort   (req_abort),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_id      (cmd_id),
        .cmd_burst   (cmd_burst),
        .cmd_size    (cmd_size),
        .cmd_len     (cmd_len),
        .cmd_ready   (cmd_ready),
        .cmd_abort   (cmd_abort)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         id;
        logic [15:0] addr;
        logic [15:0] len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } cmd_t;

    cmd_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   cyc = 0;

    int          m_state = 0;
    int          m_ptr = 0;
    int          m_last_id = 0;
    bit          m_last_vld = 0;
    logic [3:0]  m_err = '0;
    logic [3:0]  m_abort = '0;
    int          win;
    logic [3:0]  exp_rdy;
    logic [3:0]  n_abort;
    cmd_t        e;
    cmd_t        ne;

    // Reference model and scoreboard, sampled on the falling edge
    always @(negedge AXI_ACLK) begin
        cyc++;
        if (!AXI_ARESETN) begin
            m_state = 0; m_ptr = 0; m_last_id = 0; m_last_vld = 0;
            m_err = '0; m_abort = '0;
            sb.delete();
        end else begin
            win = -1;
            exp_rdy = '0;
            if (m_state == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % N] && cfg_en[(m_ptr + k) % N])
                        win = (m_ptr + k) % N;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            check_eq("req_ready", req_ready, exp_rdy);
            check_eq("req_err", req_err, m_err);
            check_eq("req_abort", req_abort, m_abort);
            check_eq("cmd_valid", cmd_valid, (m_state == 1));
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end

            n_abort = m_last_vld ? (4'b0001 << m_last_id) : 4'b0000;
            if (!cmd_abort) n_abort = '0;
            m_err = '0;

            if (m_state == 1) begin
                if (sb.size() > 0) begin
                    e = sb[0];
                    check_eq("cmd_id", cmd_id, e.id);
                    check_eq("cmd_addr", cmd_addr, e.addr);
                    check_eq("cmd_len", cmd_len, e.len);
                    check_eq("cmd_size", cmd_size, e.size);
                    check_eq("cmd_burst", cmd_burst, e.burst);
                    if (cmd_ready) begin
                        m_last_id = e.id;
                        m_last_vld = 1;
                        void'(sb.pop_front());
                        m_state = 0;
                    end
                end
            end else if (win >= 0) begin
                ne.id    = win;
                ne.addr  = req_addr[win*AW +: AW];
                ne.len   = req_len[win*AW +: AW];
                ne.size  = req_size[win*3 +: 3];
                ne.burst = req_burst[win*2 +: 2];
                if (ne.len != 0 && ne.burst != 2'b11 && ne.size <= TB_MAX_SIZE) begin
                    sb.push_back(ne);
                    m_state = 1;
                end else begin
                    m_err[win] = 1'b1;
                end
                m_ptr = (win + 1) % N;
            end
            m_abort = n_abort;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] addr, input logic [15:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        req_addr[i*AW +: AW] = addr;
        req_len[i*AW +: AW]  = len;
        req_size[i*3 +: 3]   = size;
        req_burst[i*2 +: 2]  = burst;
        req_valid[i]         = 1'b1;
    endtask

    task automatic all_legal();
        for (int i = 0; i < N; i++)
            set_req(i, 16'(32'h1000 + i * 256), 16'(64 + i), 3'(i % 3), 2'(i % 3));
    endtask

    task automatic do_reset();
        AXI_ARESETN = 1'b0;
        req_valid = '0; cmd_ready = 1'b0; cmd_abort = 1'b0; cfg_en = 4'hF;
        cycles(2);
        AXI_ARESETN = 1'b1;
        grant_log.delete();
        grant_cyc.delete();
    endtask

    task automatic check_log(input string tag, input int k, input int exp);
        check_eq(tag, (k < grant_log.size()) ? grant_log[k] : -1, exp);
    endtask

    initial begin
        req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
        req_valid = '0; cfg_en = 4'hF; cmd_ready = 1'b0; cmd_abort = 1'b0;
        cycles(2);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_cmd_addr", cmd_addr, 0);
        check_eq("rst_cmd_id", cmd_id, 0);
        check_eq("rst_cmd_len", cmd_len, 0);
        check_eq("rst_req_err", req_err, 0);
        check_eq("rst_req_abort", req_abort, 0);

        // single legal request with stalled cmd_ready
        do_reset();
        set_req(1, 16'h00FF, 16'd1052, 3'd2, 2'b01);
        #1 check_eq("t1_ready", req_ready, 4'b0010);
        cycles(1);
        req_valid = '0;
        check_eq("t1_valid", cmd_valid, 1);
        check_eq("t1_id", cmd_id, 1);
        check_eq("t1_addr", cmd_addr, 16'h00FF);
        check_eq("t1_len", cmd_len, 16'd1052);
        cycles(5);
        check_eq("t1_hold_valid", cmd_valid, 1);
        check_eq("t1_hold_addr", cmd_addr, 16'h00FF);
        check_eq("t1_ready_idle", req_ready, 0);
        cmd_ready = 1'b1;
        cycles(1);
        cmd_ready = 1'b0;
        check_eq("t1_drop", cmd_valid, 0);
        check_eq("t1_grants", grant_log.size(), 1);

        // fairness with all requesters valid
        do_reset();
        all_legal();
        cmd_ready = 1'b1;
        cycles(12);
        req_valid = '0;
        cycles(2);
        check_eq("fair_count", grant_log.size(), 6);
        for (int k = 0; k < 6; k++) check_log($sformatf("fair_grant%0d", k), k, k % 4);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("fair_gap%0d", k),
                     (k + 1 < grant_cyc.size()) ? grant_cyc[k+1] - grant_cyc[k] : -1, 2);

        // rejects: zero length, reserved burst, oversize
        do_reset();
        set_req(2, 16'h0010, 16'd0, 3'd2, 2'b01);
        cycles(1);
        req_valid = '0;
        check_eq("rej_len", req_err, 4'b0100);
        check_eq("rej_len_cmd", cmd_valid, 0);
        set_req(3, 16'h0020, 16'd8, 3'd2, 2'b11);
        cycles(1);
        req_valid = '0;
        check_eq("rej_burst", req_err, 4'b1000);
        set_req(0, 16'h0030, 16'd8, 3'd3, 2'b01);
        cycles(1);
        req_valid = '0;
        check_eq("rej_size", req_err, 4'b0001);
        check_eq("rej_size_cmd", cmd_valid, 0);
        cycles(1);
        check_eq("rej_err_clear", req_err, 0);
        grant_log.delete();
        all_legal();
        cmd_ready = 1'b1;
        cycles(1);
        req_valid = '0;
        cycles(2);
        check_log("rej_ptr", 0, 1);

        // enable mask 1010
        do_reset();
        cfg_en = 4'b1010;
        all_legal();
        cmd_ready = 1'b1;
        cycles(8);
        req_valid = '0;
        cycles(2);
        for (int k = 0; k < 4; k++) check_log($sformatf("mask_grant%0d", k), k, (k % 2 == 0) ? 1 : 3);

        // abort routing
        do_reset();
        cmd_abort = 1'b1;
        cycles(1);
        cmd_abort = 1'b0;
        check_eq("abort_none", req_abort, 0);
        set_req(2, 16'h0200, 16'd4, 3'd1, 2'b10);
        cmd_ready = 1'b1;
        cycles(1);
        req_valid = '0;
        cycles(1);
        cmd_abort = 1'b1;
        cycles(1);
        cmd_abort = 1'b0;
        check_eq("abort_r2", req_abort, 4'b0100);
        set_req(0, 16'h0300, 16'd2, 3'd0, 2'b00);
        cmd_ready = 1'b0;
        cycles(1);
        req_valid = '0;
        cmd_ready = 1'b1;
        cmd_abort = 1'b1;
        cycles(1);
        cmd_ready = 1'b0;
        check_eq("abort_hs_edge", req_abort, 4'b0100);
        check_eq("abort_hs_valid", cmd_valid, 0);
        cycles(1);
        cmd_abort = 1'b0;
        check_eq("abort_r0", req_abort, 4'b0001);

        // asynchronous reset while a command is held
        do_reset();
        set_req(3, 16'h0400, 16'd16, 3'd2, 2'b01);
        cycles(1);
        req_valid = '0;
        check_eq("mid_valid", cmd_valid, 1);
        #2 AXI_ARESETN = 1'b0;
        #1 check_eq("mid_async_valid", cmd_valid, 0);
        check_eq("mid_async_id", cmd_id, 0);
        cycles(2);
        AXI_ARESETN = 1'b1;
        grant_log.delete();
        all_legal();
        cmd_ready = 1'b1;
        cycles(2);
        req_valid = '0;
        cycles(2);
        check_log("mid_first_grant", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_dma_cmd_arb.md
Name: axi_dma_cmd_arb

Overview:
Round-robin arbiter that shares the single DMA command port of axi_top (cmd_valid/cmd_ready, cmd_abort) between NUM_REQ requesters.
- Validates each request before forwarding it.
- Stamps cmd_id with the requester index.
- Routes the downstream cmd_abort back to the requester that owns the last issued command.
- Sits between the requester front-ends and axi_top's command interface.

Parameters:
- NUM_REQ, 4, number of requesters; must equal 2**AXI_ID_WD or less.
- AXI_ID_WD, 2, width of cmd_id.
- AXI_ADDR_WD, 16, width of address and length fields.
- AXI_DATA_WD, 32, data width; the maximum legal cmd_size is log2(AXI_DATA_WD/8).

Ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
- cfg_en  in  NUM_REQ  per-requester enable; disabled requesters are never granted.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_addr  in  NUM_REQ*AXI_ADDR_WD  flattened start addresses; requester i occupies slice i.
- req_len  in  NUM_REQ*AXI_ADDR_WD  flattened transfer lengths.
- req_size  in  NUM_REQ*3  flattened AXI sizes.
- req_burst  in  NUM_REQ*2  flattened AXI burst types.
- req_ready  out  NUM_REQ  one-hot accept to the granted requester.
- req_err  out  NUM_REQ  one-cycle reject pulse.
- req_abort  out  NUM_REQ  one-cycle abort pulse.
- cmd_valid  out  1  command valid to axi_top.
- cmd_addr  out  AXI_ADDR_WD  command address.
- cmd_id  out  AXI_ID_WD  command ID.
- cmd_burst  out  2  command burst type.
- cmd_size  out  3  command size.
- cmd_len  out  AXI_ADDR_WD  command length.
- cmd_ready  in  1  ready from axi_top.
- cmd_abort  in  1  abort pulse from axi_top.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, last_vld=0, last_id=0. cmd_valid=0 and all cmd_* fields=0. req_err=0, req_abort=0.
- Reset is asynchronous. Reset mid-ISSUE drops the held command with no acknowledgement to the requester.
- FSM has two states, IDLE and ISSUE.
- IDLE arbitration:
  - Candidates are req_valid & cfg_en.
  - Winner g is the first set candidate searching upward from rr_ptr, wrapping at NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; req_ready=0 in all other cases.
  - The requester handshake completes in that cycle.
- Validation of the winner, evaluated in the same IDLE cycle. The request is illegal if any of:
  - req_len==0
  - req_burst==2'b11
  - req_size>log2(AXI_DATA_WD/8)
- Illegal winner:
  - req_err[g] pulses for one cycle, on the next edge.
  - Nothing is forwarded; state stays IDLE.
  - rr_ptr becomes (g+1) mod NUM_REQ.
- Legal winner:
  - On the next edge, register addr, len, size and burst into the cmd_* outputs.
  - cmd_id becomes g (zero-extended); cmd_valid becomes 1; state becomes ISSUE; rr_ptr becomes (g+1) mod NUM_REQ.
- ISSUE:
  - cmd_valid and all cmd_* fields are held stable until cmd_ready=1.
  - On the handshake edge: cmd_valid becomes 0, last_id becomes cmd_id, last_vld becomes 1, state becomes IDLE.
- Latency and throughput:
  - req_valid to cmd_valid takes 1 cycle.
  - Maximum rate is one command per 2 cycles; back-to-back grants are not supported.
- No candidates: IDLE holds and rr_ptr is unchanged.
- cfg_en changes take effect in the next arbitration cycle. Clearing cfg_en for a requester whose command is already in ISSUE does not cancel that command.
- Abort routing:
  - cmd_abort=1 with last_vld=1 produces req_abort[last_id] as a one-cycle pulse on the next edge.
  - cmd_abort=1 with last_vld=0 is ignored.
  - The abort always targets the last issued command, including when cmd_abort coincides with a handshake edge.
  - If cmd_abort and a handshake occur in the same cycle, the pulse goes to the previous last_id (pre-update value).
- Simultaneous req_err and req_abort on different indices are both produced.

Decomposition:
- Shared package/header axi_dma_defs holds:
  - burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10, RSVD=2'b11;
  - the size encodings;
  - the MAX_SIZE(data_wd) function.
- One sub-module, rr_arb_core: a parameterised NUM_REQ round-robin picker with inputs req_mask and rr_ptr, and outputs one-hot grant, grant index and any_grant. It is purely combinational and reused by the future response mux.
- The FSM, registers, validation and abort routing stay in axi_dma_cmd_arb.

Test Plan:
- Single legal request: req_valid[1] with addr=0x00FF, len=1052, size=2, burst=1 → req_ready[1] for 1 cycle. Next cycle cmd_valid=1, cmd_id=1, cmd_addr=0x00FF, cmd_len=1052. Fields stay stable while cmd_ready is held 0 for 5 cycles; cmd_valid drops after the handshake.
- Fairness: all 4 requesters continuously valid and cmd_ready=1 → grant order 0,1,2,3,0,1. Commands issue on every second cycle.
- Rejects: req_len=0 on req 2, then burst=2'b11 on req 3, then size=3 on req 0 → each gets a one-cycle req_err pulse. cmd_valid stays 0 and rr_ptr advances past each.
- Enable mask: cfg_en=4'b1010 with all requesters valid → only requesters 1 and 3 are granted, alternating.
- Abort routing:
  - cmd_abort before any issue → no req_abort.
  - After issuing from requester 2, cmd_abort → req_abort=4'b0100 pulse.
  - cmd_abort on the same edge as requester 0's handshake → the pulse still goes to requester 2.
- Reset mid-ISSUE: deassert AXI_ARESETN while cmd_valid=1 → cmd_valid=0 immediately (asynchronous). After release the next grant starts from requester 0.
